// File: rtl/mano_ram_access_ctrl.sv
// mano_ram_access_ctrl
//   Sequences every access to the 16x8 asynchronous RAM and arbitrates it
//   between the CPU (port c) and the program loader / front panel (port l).
//   The RAM write is level-sensitive while ram_R_W=0. The address and write
//   data therefore come straight from registers that were loaded one cycle
//   earlier, so they cannot change while R_W is low.
//
// Ports
//   CLK, RST_N            clock (rising edge), asynchronous active-low reset
//   c_req/c_we/c_addr/    CPU request (level, held until c_ack), access type
//   c_wdata/c_ack         (1=write), address, write data, one-cycle ack pulse
//   l_req/l_we/l_addr/    loader request port, same protocol as the CPU port
//   l_wdata/l_ack
//   rdata                 last captured read data, valid with the ack of a read
//   ram_address           RAM address
//   ram_R_W               RAM control: 1=read/idle, 0=write
//   ram_Data_Bus          RAM data bus, driven only while ram_R_W=0
//   busy                  high in every state except IDLE
//   grant_l               loader owns the current/last transaction
module mano_ram_access_ctrl #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8,
  parameter int READ_WAIT = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_ack,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_ack,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_R_W,
  inout  wire  [DATA_W-1:0] ram_Data_Bus,
  output logic              busy,
  output logic              grant_l
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    WRITE,
    READ,
    DONE
  } state_t;

  localparam int CNT_W = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(READ_WAIT - 1);

  state_t            state;
  logic              lat_we;
  logic [DATA_W-1:0] lat_wdata;
  logic [CNT_W-1:0]  read_cnt;
  logic              last_l;
  logic              drive_en;
  logic              pick_l;

  // The loader wins only when the CPU is not asking, or on a tie when the CPU
  // was served last. last_l resets to 1 so the CPU wins the first tie.
  assign pick_l = l_req && (!c_req || !last_l);

  // drive_en is loaded on the same edges as ram_R_W, always with its inverse.
  // The bus is therefore released in the same instant R_W returns high, and
  // reset releases both at once.
  assign ram_Data_Bus = drive_en ? lat_wdata : {DATA_W{1'bz}};

  // Single-process FSM. Every output is a flop. ram_address doubles as the
  // latched request address, so it stays fixed from SETUP through DONE.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      lat_we      <= 1'b0;
      lat_wdata   <= '0;
      read_cnt    <= '0;
      last_l      <= 1'b1;
      drive_en    <= 1'b0;
      ram_R_W     <= 1'b1;
      ram_address <= '0;
      rdata       <= '0;
      c_ack       <= 1'b0;
      l_ack       <= 1'b0;
      busy        <= 1'b0;
      grant_l     <= 1'b0;
    end else begin
      c_ack <= 1'b0;
      l_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (c_req || l_req) begin
            state       <= SETUP;
            busy        <= 1'b1;
            grant_l     <= pick_l;
            lat_we      <= pick_l ? l_we    : c_we;
            ram_address <= pick_l ? l_addr  : c_addr;
            lat_wdata   <= pick_l ? l_wdata : c_wdata;
          end
        end
        SETUP: begin
          read_cnt <= '0;
          if (lat_we) begin
            state    <= WRITE;
            ram_R_W  <= 1'b0;
            drive_en <= 1'b1;
          end else begin
            state <= READ;
          end
        end
        WRITE: begin
          state    <= DONE;
          ram_R_W  <= 1'b1;
          drive_en <= 1'b0;
          c_ack    <= ~grant_l;
          l_ack    <= grant_l;
        end
        READ: begin
          // The RAM has had READ_WAIT full cycles of stable address by now.
          if (read_cnt == LAST_CNT) begin
            state <= DONE;
            rdata <= ram_Data_Bus;
            c_ack <= ~grant_l;
            l_ack <= grant_l;
          end else begin
            read_cnt <= read_cnt + 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy   <= 1'b0;
          last_l <= grant_l;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mano_ram_access_ctrl.sv
// tb_mano_ram_access_ctrl
//   Directed bench for mano_ram_access_ctrl. It uses two instances: dut with
//   READ_WAIT=1 and dut3 with READ_WAIT=3. Each instance has a behavioural
//   16x8 RAM. The RAM drives the bus while R_W=1 and its output enable is set.
//   It writes on the falling clock edge while R_W=0.
module tb_mano_ram_access_ctrl;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  logic       c_req = 0, c_we = 0, l_req = 0, l_we = 0;
  logic [3:0] c_addr = 0, l_addr = 0;
  logic [7:0] c_wdata = 0, l_wdata = 0;
  logic       c_ack, l_ack, ram_R_W, busy, grant_l;
  logic [7:0] rdata;
  logic [3:0] ram_address;
  wire  [7:0] ram_Data_Bus;
  logic       ram_oe = 1'b1;
  logic [7:0] mem [16];

  logic       w3_c_req = 0, w3_c_we = 0, w3_l_req = 0, w3_l_we = 0;
  logic [3:0] w3_c_addr = 0, w3_l_addr = 0;
  logic [7:0] w3_c_wdata = 0, w3_l_wdata = 0;
  logic       w3_c_ack, w3_l_ack, w3_R_W, w3_busy, w3_grant_l;
  logic [7:0] w3_rdata;
  logic [3:0] w3_address;
  wire  [7:0] w3_bus;
  logic       ram_oe3 = 1'b1;
  logic [7:0] mem3 [16];

  mano_ram_access_ctrl #(.ADDR_W(4), .DATA_W(8), .READ_WAIT(1)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_ack(c_ack),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata), .l_ack(l_ack),
    .rdata(rdata), .ram_address(ram_address), .ram_R_W(ram_R_W),
    .ram_Data_Bus(ram_Data_Bus), .busy(busy), .grant_l(grant_l)
  );

  mano_ram_access_ctrl #(.ADDR_W(4), .DATA_W(8), .READ_WAIT(3)) dut3 (
    .CLK(CLK), .RST_N(RST_N),
    .c_req(w3_c_req), .c_we(w3_c_we), .c_addr(w3_c_addr), .c_wdata(w3_c_wdata), .c_ack(w3_c_ack),
    .l_req(w3_l_req), .l_we(w3_l_we), .l_addr(w3_l_addr), .l_wdata(w3_l_wdata), .l_ack(w3_l_ack),
    .rdata(w3_rdata), .ram_address(w3_address), .ram_R_W(w3_R_W),
    .ram_Data_Bus(w3_bus), .busy(w3_busy), .grant_l(w3_grant_l)
  );

  // Behavioural asynchronous RAMs
  assign ram_Data_Bus = (ram_oe && ram_R_W) ? mem[ram_address] : 8'bz;
  always @(negedge CLK) if (!ram_R_W) mem[ram_address] <= ram_Data_Bus;

  assign w3_bus = (ram_oe3 && w3_R_W) ? mem3[w3_address] : 8'bz;
  always @(negedge CLK) if (!w3_R_W) mem3[w3_address] <= w3_bus;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset;
    RST_N = 1'b0;
    #2;
    RST_N = 1'b1;
    tick();
  endtask

  // One transaction on the main instance, started while it is IDLE.
  // lat counts the busy cycles up to and including the ack cycle.
  task automatic access(input logic use_l, input logic we, input logic [3:0] addr,
                        input logic [7:0] wd, output int lat, output int nlow,
                        output logic addr_ok, output logic got_ack);
    lat = 0; nlow = 0; addr_ok = 1'b1; got_ack = 1'b0;
    if (use_l) begin
      l_req = 1; l_we = we; l_addr = addr; l_wdata = wd;
    end else begin
      c_req = 1; c_we = we; c_addr = addr; c_wdata = wd;
    end
    for (int i = 0; i < 20 && !got_ack; i++) begin
      tick();
      if (busy) begin
        lat++;
        if (ram_address !== addr) addr_ok = 1'b0;
      end
      if (!ram_R_W) nlow++;
      if (use_l ? l_ack : c_ack) got_ack = 1'b1;
    end
    c_req = 0;
    l_req = 0;
  endtask

  task automatic test_reset;
    #12;
    checks++; if (ram_R_W !== 1'b1) begin errors++; $display("[TB] FAIL reset_rw: got %b expected 1", ram_R_W); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (c_ack !== 1'b0) begin errors++; $display("[TB] FAIL reset_c_ack: got %b expected 0", c_ack); end
    checks++; if (l_ack !== 1'b0) begin errors++; $display("[TB] FAIL reset_l_ack: got %b expected 0", l_ack); end
    checks++; if (grant_l !== 1'b0) begin errors++; $display("[TB] FAIL reset_grant_l: got %b expected 0", grant_l); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("[TB] FAIL reset_rdata: got %h expected 00", rdata); end
    checks++; if (ram_address !== 4'h0) begin errors++; $display("[TB] FAIL reset_addr: got %h expected 0", ram_address); end
    @(posedge CLK); #1;
    RST_N = 1'b1;
    tick();
  endtask

  task automatic test_cpu_write_read;
    int lat, nlow; logic aok, ack;
    access(1'b0, 1'b1, 4'h3, 8'hA5, lat, nlow, aok, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("[TB] FAIL wr_ack: got %b expected 1", ack); end
    checks++; if (lat != 3) begin errors++; $display("[TB] FAIL wr_latency: got %0d expected 3", lat); end
    checks++; if (nlow != 1) begin errors++; $display("[TB] FAIL wr_rw_low_cycles: got %0d expected 1", nlow); end
    checks++; if (aok !== 1'b1) begin errors++; $display("[TB] FAIL wr_addr_stable: got %b expected 1", aok); end
    checks++; if (mem[3] !== 8'hA5) begin errors++; $display("[TB] FAIL wr_mem3: got %h expected a5", mem[3]); end
    access(1'b0, 1'b0, 4'h3, 8'h00, lat, nlow, aok, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("[TB] FAIL rd_ack: got %b expected 1", ack); end
    checks++; if (lat != 3) begin errors++; $display("[TB] FAIL rd_latency: got %0d expected 3", lat); end
    checks++; if (rdata !== 8'hA5) begin errors++; $display("[TB] FAIL rd_data: got %h expected a5", rdata); end
    checks++; if (nlow != 0) begin errors++; $display("[TB] FAIL rd_rw_low_cycles: got %0d expected 0", nlow); end
    checks++; if (grant_l !== 1'b0) begin errors++; $display("[TB] FAIL rd_grant_l: got %b expected 0", grant_l); end
  endtask

  task automatic test_reset_mid_write;
    logic seen, ack_seen;
    seen = 0; ack_seen = 0;
    ram_oe = 1'b0;
    c_req = 1; c_we = 1; c_addr = 4'h5; c_wdata = 8'hC3;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (!ram_R_W) seen = 1'b1;
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL rst_reach_write: got %b expected 1", seen); end
    #2;
    RST_N = 1'b0;
    #1;
    checks++; if (ram_R_W !== 1'b1) begin errors++; $display("[TB] FAIL rst_async_rw: got %b expected 1", ram_R_W); end
    checks++; if (ram_Data_Bus === 8'hC3) begin errors++; $display("[TB] FAIL rst_async_bus: got %h expected released", ram_Data_Bus); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_async_busy: got %b expected 0", busy); end
    checks++; if (ram_address !== 4'h0) begin errors++; $display("[TB] FAIL rst_async_addr: got %h expected 0", ram_address); end
    c_req = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (c_ack || l_ack) ack_seen = 1'b1;
    end
    RST_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (c_ack || l_ack) ack_seen = 1'b1;
    end
    checks++; if (ack_seen !== 1'b0) begin errors++; $display("[TB] FAIL rst_no_ack: got %b expected 0", ack_seen); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_idle_after: got %b expected 0", busy); end
    ram_oe = 1'b1;
  endtask

  task automatic test_simultaneous;
    int order [2]; logic g [2]; int n, lat, nlow; logic aok, ack;
    order[0] = -1; order[1] = -1; g[0] = 1'bx; g[1] = 1'bx; n = 0;
    apply_reset();
    c_req = 1; c_we = 1; c_addr = 4'h0; c_wdata = 8'h11;
    l_req = 1; l_we = 1; l_addr = 4'h1; l_wdata = 8'h22;
    for (int i = 0; i < 30 && n < 2; i++) begin
      tick();
      if (c_ack && n < 2) begin order[n] = 0; g[n] = grant_l; n++; c_req = 0; end
      if (l_ack && n < 2) begin order[n] = 1; g[n] = grant_l; n++; l_req = 0; end
    end
    c_req = 0; l_req = 0;
    checks++; if (n != 2) begin errors++; $display("[TB] FAIL sim_ack_count: got %0d expected 2", n); end
    checks++; if (order[0] != 0) begin errors++; $display("[TB] FAIL sim_first_cpu: got %0d expected 0", order[0]); end
    checks++; if (order[1] != 1) begin errors++; $display("[TB] FAIL sim_second_loader: got %0d expected 1", order[1]); end
    checks++; if (g[0] !== 1'b0) begin errors++; $display("[TB] FAIL sim_grant0: got %b expected 0", g[0]); end
    checks++; if (g[1] !== 1'b1) begin errors++; $display("[TB] FAIL sim_grant1: got %b expected 1", g[1]); end
    access(1'b0, 1'b0, 4'h0, 8'h00, lat, nlow, aok, ack);
    checks++; if (ack !== 1'b1 || rdata !== 8'h11) begin errors++; $display("[TB] FAIL sim_read0: ack %b data %h expected 1/11", ack, rdata); end
    access(1'b1, 1'b0, 4'h1, 8'h00, lat, nlow, aok, ack);
    checks++; if (ack !== 1'b1 || rdata !== 8'h22) begin errors++; $display("[TB] FAIL sim_read1: ack %b data %h expected 1/22", ack, rdata); end
    checks++; if (grant_l !== 1'b1) begin errors++; $display("[TB] FAIL sim_read1_grant: got %b expected 1", grant_l); end
  endtask

  task automatic test_starvation;
    logic seq [6]; int ack_t [6]; int n; logic port_ok, spacing_ok;
    n = 0; port_ok = 1; spacing_ok = 1;
    for (int k = 0; k < 6; k++) begin seq[k] = 1'bx; ack_t[k] = 0; end
    apply_reset();
    c_req = 1; c_we = 0; c_addr = 4'h3;
    l_req = 1; l_we = 0; l_addr = 4'h1;
    for (int i = 0; i < 100 && n < 6; i++) begin
      tick();
      if (c_ack || l_ack) begin
        if ((c_ack && l_ack) || (c_ack && grant_l) || (l_ack && !grant_l)) port_ok = 0;
        seq[n] = grant_l; ack_t[n] = i; n++;
      end
    end
    c_req = 0; l_req = 0;
    checks++; if (n != 6) begin errors++; $display("[TB] FAIL starve_count: got %0d expected 6", n); end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (seq[k] !== k[0]) begin errors++; $display("[TB] FAIL starve_grant%0d: got %b expected %b", k, seq[k], k[0]); end
      if (k > 0 && ack_t[k] - ack_t[k-1] != 4) spacing_ok = 0;
    end
    checks++; if (port_ok !== 1'b1) begin errors++; $display("[TB] FAIL starve_ack_port: got %b expected 1", port_ok); end
    checks++; if (spacing_ok !== 1'b1) begin errors++; $display("[TB] FAIL starve_period: got %b expected 1", spacing_ok); end
    tick(); tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL starve_idle: got %b expected 0", busy); end
  endtask

  task automatic test_input_instability;
    int lat, nlow; logic aok, ack, changed;
    access(1'b0, 1'b0, 4'h0, 8'h00, lat, nlow, aok, ack);
    checks++; if (ack !== 1'b1 || rdata !== 8'h11) begin errors++; $display("[TB] FAIL inst_pre_read: ack %b data %h expected 1/11", ack, rdata); end
    access(1'b0, 1'b1, 4'h9, 8'h77, lat, nlow, aok, ack);
    checks++; if (rdata !== 8'h11) begin errors++; $display("[TB] FAIL inst_rdata_hold: got %h expected 11", rdata); end
    c_req = 1; c_we = 1; c_addr = 4'h2; c_wdata = 8'h5A;
    changed = 0; ack = 0;
    for (int i = 0; i < 20 && !ack; i++) begin
      tick();
      if (busy && !changed) begin c_addr = 4'h9; c_wdata = 8'hFF; c_we = 0; changed = 1; end
      if (c_ack) ack = 1;
    end
    c_req = 0;
    checks++; if (ack !== 1'b1) begin errors++; $display("[TB] FAIL inst_ack: got %b expected 1", ack); end
    checks++; if (mem[2] !== 8'h5A) begin errors++; $display("[TB] FAIL inst_mem2: got %h expected 5a", mem[2]); end
    checks++; if (mem[9] !== 8'h77) begin errors++; $display("[TB] FAIL inst_mem9: got %h expected 77", mem[9]); end
    access(1'b0, 1'b0, 4'h2, 8'h00, lat, nlow, aok, ack);
    checks++; if (ack !== 1'b1 || rdata !== 8'h5A) begin errors++; $display("[TB] FAIL inst_read2: ack %b data %h expected 1/5a", ack, rdata); end
    access(1'b1, 1'b0, 4'hF, 8'h00, lat, nlow, aok, ack);
    checks++; if (ack !== 1'b1 || rdata !== mem[15]) begin errors++; $display("[TB] FAIL inst_readF: ack %b data %h expected 1/%h", ack, rdata, mem[15]); end
  endtask

  task automatic test_read_wait;
    int lat, nlow; logic ack, aok;
    ram_oe3 = 1'b0;
    w3_c_req = 1; w3_c_we = 1; w3_c_addr = 4'h7; w3_c_wdata = 8'hC6;
    nlow = 0; ack = 0;
    for (int i = 0; i < 20 && !ack; i++) begin
      tick();
      checks++;
      if (w3_R_W) begin
        if (w3_bus === 8'hC6) begin errors++; $display("[TB] FAIL own_released: got %h expected released", w3_bus); end
      end else begin
        nlow++;
        if (w3_bus !== 8'hC6) begin errors++; $display("[TB] FAIL own_driven: got %h expected c6", w3_bus); end
      end
      if (w3_c_ack) ack = 1;
    end
    w3_c_req = 0;
    checks++; if (ack !== 1'b1) begin errors++; $display("[TB] FAIL rw3_wr_ack: got %b expected 1", ack); end
    checks++; if (nlow != 1) begin errors++; $display("[TB] FAIL rw3_rw_low_cycles: got %0d expected 1", nlow); end
    checks++; if (mem3[7] !== 8'hC6) begin errors++; $display("[TB] FAIL rw3_mem7: got %h expected c6", mem3[7]); end
    ram_oe3 = 1'b1;
    w3_c_req = 1; w3_c_we = 0; w3_c_addr = 4'h7;
    lat = 0; ack = 0; aok = 1;
    for (int i = 0; i < 20 && !ack; i++) begin
      tick();
      if (w3_busy) begin
        lat++;
        if (w3_address !== 4'h7 || w3_R_W !== 1'b1) aok = 0;
      end
      if (lat == 4 && !w3_c_ack) begin
        checks++;
        if (w3_rdata !== 8'h00) begin errors++; $display("[TB] FAIL rw3_early_capture: got %h expected 00", w3_rdata); end
      end
      if (w3_c_ack) ack = 1;
    end
    w3_c_req = 0;
    checks++; if (ack !== 1'b1) begin errors++; $display("[TB] FAIL rw3_rd_ack: got %b expected 1", ack); end
    checks++; if (lat != 5) begin errors++; $display("[TB] FAIL rw3_latency: got %0d expected 5", lat); end
    checks++; if (w3_rdata !== 8'hC6) begin errors++; $display("[TB] FAIL rw3_rdata: got %h expected c6", w3_rdata); end
    checks++; if (aok !== 1'b1) begin errors++; $display("[TB] FAIL rw3_stable: got %b expected 1", aok); end
  endtask

  initial begin
    test_reset();
    test_cpu_write_read();
    test_reset_mid_write();
    test_simultaneous();
    test_starvation();
    test_input_instability();
    test_read_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mano_ram_access_ctrl.md
Name: mano_ram_access_ctrl

Overview:
- Sequences every access to the 16x8 asynchronous RAM and shares it between two requesters: CPU (port c) and program loader/front panel (port l).
- Owns the RAM address, R_W and the Data_Bus driver.
- Guarantees address and data are stable for the whole interval R_W=0, so the RAM's level-sensitive write never latches a transient.
- Returns read data through a registered capture.

Parameters:
ADDR_W, 4, RAM address width
DATA_W, 8, RAM data width
READ_WAIT, 1, cycles R_W held high with address stable before read data is captured (>=1)

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  asynchronous active-low reset
c_req  in  1  CPU request; level, held until c_ack
c_we  in  1  CPU access type: 1=write, 0=read
c_addr  in  ADDR_W  CPU address
c_wdata  in  DATA_W  CPU write data
c_ack  out  1  one-cycle completion pulse to CPU
l_req  in  1  loader request
l_we  in  1  loader access type
l_addr  in  ADDR_W  loader address
l_wdata  in  DATA_W  loader write data
l_ack  out  1  one-cycle completion pulse to loader
rdata  out  DATA_W  last captured read data; valid with ack of a read
ram_address  out  ADDR_W  RAM address
ram_R_W  out  1  RAM control: 1=read/idle, 0=write
ram_Data_Bus  inout  DATA_W  RAM data bus; driven only while ram_R_W=0
busy  out  1  high in every state except IDLE
grant_l  out  1  loader owns the current/last transaction

Behaviour:
- Interface: one clock, CLK. Reset RST_N is asynchronous, active-low.
- Reset (asynchronous, effective immediately, also mid-transaction):
  - state=IDLE, ram_R_W=1, Data_Bus released (Z), ram_address=0.
  - rdata=0, c_ack=l_ack=0, busy=0, grant_l=0.
  - Round-robin pointer = "last served loader", so the CPU wins the first tie.
  - A write in progress is aborted by forcing R_W high; the RAM location may hold the partially written value, with no other side effects.
- All outputs are registered. ram_Data_Bus output enable is the registered inverse of ram_R_W, so contention is impossible.
- States:
  - IDLE: sample c_req/l_req.
    - None asserted: stay.
    - One asserted: grant it.
    - Both asserted: grant the requester not served last.
    - On grant: latch we, addr and wdata into internal registers, set grant_l, go SETUP.
  - SETUP (1 cycle): ram_address=latched addr, ram_R_W=1, bus released. Next state is WRITE if we=1, else READ.
  - WRITE (exactly 1 cycle): ram_R_W=0, bus driven with latched wdata, address unchanged. Next state DONE.
  - READ (READ_WAIT cycles, counter): ram_R_W=1, bus released. At the edge ending the last READ cycle, capture ram_Data_Bus into rdata. Next state DONE.
  - DONE (1 cycle): ram_R_W=1, bus released, address held. Pulse the ack of the granted requester. Update the round-robin pointer. Next state IDLE.
- Latency from the IDLE grant edge to the ack cycle:
  - write: 3 cycles.
  - read: 2+READ_WAIT cycles.
  - Minimum period per transaction including IDLE: write 4, read 3+READ_WAIT.
- Handshake:
  - Requester must deassert req at the edge that samples its ack.
  - A req still high in IDLE is treated as a new transaction; back-to-back accesses are legal this way.
  - Request inputs are ignored outside IDLE. A req dropped mid-transaction does not abort it; ack still pulses.
  - Latched addr, we and wdata are immune to input changes after the grant.
- rdata holds its value until the next read capture; writes do not alter it.
- With both requesters continuously requesting, grants strictly alternate; neither requester waits more than one transaction.
- Address wrap: no arithmetic; address 4'hF is an ordinary location.

Test Plan:
- Reset: RST_N low mid-WRITE (R_W=0) -> ram_R_W=1 and bus Z within the same cycle with no clock edge; state IDLE; ack never issued.
- CPU write then read: c_we=1, c_addr=4'h3, c_wdata=8'hA5, then c_we=0, c_addr=4'h3 -> c_ack 3 cycles after the write grant, 3 after the read grant (READ_WAIT=1); rdata=8'hA5; ram_R_W low for exactly one cycle with address 4'h3 throughout.
- Simultaneous requests after reset: CPU writes 8'h11 to 4'h0 and loader writes 8'h22 to 4'h1 at the same time -> CPU served first, loader next; then a read of both addresses returns 8'h11 and 8'h22.
- Starvation check: c_req and l_req held high for 6 transactions -> grant_l sequence 0,1,0,1,0,1.
- Input instability: change c_addr to 4'h9 and c_wdata to 8'hFF one cycle after the grant of a write to 4'h2/8'h5A -> memory[2]=8'h5A and memory[9] unchanged.
- Bus ownership: monitor ram_Data_Bus in every cycle -> driven only while ram_R_W=0; with READ_WAIT=3, capture happens after 3 stable cycles and ack arrives 5 cycles after the grant.
